// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter FSM states and data words.
package cpu_types_pkg;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STARVE_W = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IGNT = 2'd1,
    ARB_DGNT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/arbiter_if.sv
// Request-side and RAM-side signals of the memory arbiter.
interface arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_types_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_types_pkg::DATA_W
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  ramstate_t         ramstate;
  logic [DATA_W-1:0] ramload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport cache (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iwait, dwait, iload, dload
  );

  modport ram (
    output ramstate, ramload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants won while instruction fetch waits.
module arb_starve_counter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic at_max_c
);
  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  assign at_max_c = (cnt_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max_c) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/memory_arbiter.sv
// Shares the single-ported RAM between instruction fetch and data access;
// data wins unless instruction fetch has been starved STARVE_MAX times.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W     = cpu_types_pkg::ADDR_W,
  parameter int unsigned DATA_W     = cpu_types_pkg::DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   CLK,
  input  logic   nRST,
  arbiter_if.arb aif
);
  arb_state_t        state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              starve_inc_c;
  logic              starve_clr_c;
  logic              starve_max_c;

  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .CLK      (CLK),
    .nRST     (nRST),
    .inc      (starve_inc_c),
    .clr      (starve_clr_c),
    .at_max_c (starve_max_c)
  );

  // RAM drive follows the registered grant, so reset drops enables at once.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    store_d      = store_q;
    starve_inc_c = 1'b0;
    starve_clr_c = 1'b0;
    aif.ramREN   = 1'b0;
    aif.ramWEN   = 1'b0;
    aif.ramaddr  = '0;
    aif.ramstore = '0;
    aif.iwait    = 1'b1;
    aif.dwait    = 1'b1;
    aif.iload    = '0;
    aif.dload    = '0;

    case (state_q)
      ARB_IDLE: begin
        if ((aif.dREN || aif.dWEN) && !(aif.iREN && starve_max_c)) begin
          state_d = ARB_DGNT;
          wr_d    = aif.dWEN;
          addr_d  = aif.daddr;
          store_d = aif.dstore;
        end else if (aif.iREN) begin
          state_d = ARB_IGNT;
          wr_d    = 1'b0;
          addr_d  = aif.iaddr;
        end
      end

      ARB_IGNT: begin
        aif.ramREN  = 1'b1;
        aif.ramaddr = addr_q;
        if (aif.ramstate == ACCESS) begin
          state_d      = ARB_IDLE;
          starve_clr_c = 1'b1;
          if (aif.iREN) begin
            aif.iwait = 1'b0;
            aif.iload = aif.ramload;
          end
        end else if (aif.ramstate == ERROR) begin
          state_d = ARB_IDLE;
        end
      end

      ARB_DGNT: begin
        aif.ramaddr  = addr_q;
        aif.ramstore = store_q;
        aif.ramWEN   = wr_q;
        aif.ramREN   = !wr_q;
        if (aif.ramstate == ACCESS) begin
          state_d      = ARB_IDLE;
          starve_inc_c = aif.iREN;
          if (aif.dREN || aif.dWEN) begin
            aif.dwait = 1'b0;
            aif.dload = wr_q ? '0 : aif.ramload;
          end
        end else if (aif.ramstate == ERROR) begin
          state_d = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: arbitration, latency, starvation, RAM error and async reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  arbiter_if aif ();

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .aif  (aif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    logic [9:0] i_mask;
    checks = 0;
    errors = 0;
    nRST = 1'b1;
    aif.iREN = 1'b1;  aif.iaddr = 32'h0000_0040;
    aif.dREN = 1'b1;  aif.dWEN = 1'b0;
    aif.daddr = 32'h0000_0080; aif.dstore = 32'h0;
    aif.ramstate = FREE; aif.ramload = 32'h0;

    // Reset with requests high
    #2 nRST = 1'b0;
    mid();
    chk("rst_ramREN", 32'(aif.ramREN), 0);
    chk("rst_ramWEN", 32'(aif.ramWEN), 0);
    chk("rst_iwait",  32'(aif.iwait), 1);
    chk("rst_dwait",  32'(aif.dwait), 1);
    chk("rst_ramaddr", aif.ramaddr, 0);
    chk("rst_iload", aif.iload, 0);
    nxt();
    nRST = 1'b1;
    aif.ramstate = BUSY;
    mid();
    chk("t1_idle_ramREN", 32'(aif.ramREN), 0);
    nxt();
    mid();
    chk("t1_dgnt_ramREN", 32'(aif.ramREN), 1);
    chk("t1_dgnt_ramWEN", 32'(aif.ramWEN), 0);
    chk("t1_dgnt_ramaddr", aif.ramaddr, 32'h80);
    chk("t1_busy_dwait", 32'(aif.dwait), 1);
    nxt();
    aif.ramstate = ACCESS; aif.ramload = 32'hA5A5_0001;
    mid();
    chk("t1_acc_dwait", 32'(aif.dwait), 0);
    chk("t1_acc_dload", aif.dload, 32'hA5A5_0001);
    chk("t1_acc_iwait", 32'(aif.iwait), 1);
    nxt();
    aif.iREN = 1'b0; aif.dREN = 1'b0; aif.ramstate = FREE;
    mid();
    chk("t1_after_ramREN", 32'(aif.ramREN), 0);
    chk("t1_after_dwait", 32'(aif.dwait), 1);
    chk("t1_after_dload", aif.dload, 0);

    // Instruction fetch with two BUSY cycles
    nxt();
    aif.iREN = 1'b1; aif.iaddr = 32'h0000_0040; aif.ramstate = BUSY;
    mid();
    chk("t2_idle_ramREN", 32'(aif.ramREN), 0);
    nxt();
    mid();
    chk("t2_b1_ramREN", 32'(aif.ramREN), 1);
    chk("t2_b1_ramaddr", aif.ramaddr, 32'h40);
    chk("t2_b1_iwait", 32'(aif.iwait), 1);
    chk("t2_b1_iload", aif.iload, 0);
    nxt();
    mid();
    chk("t2_b2_ramREN", 32'(aif.ramREN), 1);
    chk("t2_b2_iwait", 32'(aif.iwait), 1);
    nxt();
    aif.ramstate = ACCESS; aif.ramload = 32'h2008_0001;
    mid();
    chk("t2_acc_ramREN", 32'(aif.ramREN), 1);
    chk("t2_acc_ramaddr", aif.ramaddr, 32'h40);
    chk("t2_acc_iwait", 32'(aif.iwait), 0);
    chk("t2_acc_iload", aif.iload, 32'h2008_0001);
    nxt();
    aif.iREN = 1'b0; aif.ramstate = FREE;
    mid();
    chk("t2_after_iwait", 32'(aif.iwait), 1);
    chk("t2_after_iload", aif.iload, 0);
    chk("t2_after_ramREN", 32'(aif.ramREN), 0);

    // Simultaneous dREN/dWEN resolves to a write
    nxt();
    aif.dREN = 1'b1; aif.dWEN = 1'b1;
    aif.daddr = 32'h0000_0100; aif.dstore = 32'hDEAD_BEEF;
    mid();
    nxt();
    aif.ramstate = ACCESS; aif.ramload = 32'h0000_0055;
    mid();
    chk("t3_ramWEN", 32'(aif.ramWEN), 1);
    chk("t3_ramREN", 32'(aif.ramREN), 0);
    chk("t3_ramstore", aif.ramstore, 32'hDEAD_BEEF);
    chk("t3_ramaddr", aif.ramaddr, 32'h100);
    chk("t3_dwait", 32'(aif.dwait), 0);
    chk("t3_dload", aif.dload, 0);
    nxt();
    aif.dREN = 1'b0; aif.dWEN = 1'b0; aif.ramstate = FREE;
    mid();
    chk("t3_after_dwait", 32'(aif.dwait), 1);
    chk("t3_after_ramWEN", 32'(aif.ramWEN), 0);

    // Starvation: continuous iREN+dREN, RAM always ACCESS
    nxt();
    aif.iREN = 1'b1; aif.dREN = 1'b1; aif.ramstate = ACCESS; aif.ramload = 32'h77;
    i_mask = 10'b10000_10000;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk("t4_gap_ramREN", 32'(aif.ramREN), 0);
      nxt();
      mid();
      chk($sformatf("t4_g%0d_iwait", k), 32'(aif.iwait), 32'(!i_mask[k]));
      chk($sformatf("t4_g%0d_dwait", k), 32'(aif.dwait), 32'(i_mask[k]));
      nxt();
    end

    // Build starve count to 2, then ERROR during an I grant
    mid();
    nxt();
    mid();
    chk("t5_d1_dwait", 32'(aif.dwait), 0);
    nxt();
    mid();
    nxt();
    mid();
    chk("t5_d2_dwait", 32'(aif.dwait), 0);
    nxt();
    aif.dREN = 1'b0; aif.ramstate = ERROR;
    mid();
    chk("t5_cnt_pre", 32'(dut.u_starve.cnt_q), 2);
    nxt();
    mid();
    chk("t5_err_ramREN", 32'(aif.ramREN), 1);
    chk("t5_err_ramaddr", aif.ramaddr, 32'h40);
    chk("t5_err_iwait", 32'(aif.iwait), 1);
    nxt();
    mid();
    chk("t5_rearb_ramREN", 32'(aif.ramREN), 0);
    chk("t5_rearb_iwait", 32'(aif.iwait), 1);
    chk("t5_cnt_err", 32'(dut.u_starve.cnt_q), 2);
    nxt();
    aif.ramstate = ACCESS; aif.ramload = 32'h0000_1111;
    mid();
    chk("t5_acc_iwait", 32'(aif.iwait), 0);
    chk("t5_acc_iload", aif.iload, 32'h0000_1111);
    nxt();
    aif.iREN = 1'b0; aif.ramstate = FREE;
    mid();
    chk("t5_cnt_clr", 32'(dut.u_starve.cnt_q), 0);
    chk("t5_after_iwait", 32'(aif.iwait), 1);

    // Asynchronous reset mid data write
    nxt();
    aif.dWEN = 1'b1; aif.daddr = 32'h0000_0200; aif.dstore = 32'hCAFE_F00D; aif.ramstate = BUSY;
    mid();
    nxt();
    mid();
    chk("t6_pre_ramWEN", 32'(aif.ramWEN), 1);
    nRST = 1'b0;
    #1;
    chk("t6_async_ramWEN", 32'(aif.ramWEN), 0);
    chk("t6_async_ramREN", 32'(aif.ramREN), 0);
    chk("t6_async_dwait", 32'(aif.dwait), 1);
    nxt();
    nRST = 1'b1; aif.dWEN = 1'b0; aif.ramstate = ACCESS;
    mid();
    chk("t6_rel_ramWEN", 32'(aif.ramWEN), 0);
    chk("t6_rel_dwait", 32'(aif.dwait), 1);
    nxt();
    mid();
    chk("t6_idle_ramREN", 32'(aif.ramREN), 0);
    chk("t6_idle_ramWEN", 32'(aif.ramWEN), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
